// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DFLT = 16;
   localparam int DATA_W_DFLT = 16;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      XFER = 2'd2,
      RESP = 2'd3
   } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way picker: round-robin against last, or fixed port-0
// priority when MEM_ARB_FIXED_PRIO_EN is defined.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic winner,
   output logic vld
);

   always_comb begin
      vld    = req0 | req1;
      winner = PORT_CPU;
      if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         winner = PORT_CPU;
`else
         winner = (last == PORT_CPU) ? PORT_DMA : PORT_CPU;
`endif
      end else if (req1) begin
         winner = PORT_DMA;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port sequencer for single-ported memory: grant, latch MAR, access, done; 4 cycles per access.
// Requests are held until done; MEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority over round-robin.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DFLT,
   parameter int DATA_W = DATA_W_DFLT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              done0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_addr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_in_en,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_out_en,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t              state_q;
   logic                last_q;
   logic                port_q;
   logic                we_q;
   logic                gnt0_q, gnt1_q, done0_q, done1_q;
   logic                mem_addr_en_q, mem_in_en_q, mem_out_en_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                pick_port;
   logic                pick_vld;

   mem_arb_pick u_pick (
      .req0   (req0),
      .req1   (req1),
      .last   (last_q),
      .winner (pick_port),
      .vld    (pick_vld)
   );

   // mem_addr/mem_wdata double as the command register: loaded only at grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         last_q        <= PORT_DMA;
         port_q        <= PORT_CPU;
         we_q          <= 1'b0;
         gnt0_q        <= 1'b0;
         gnt1_q        <= 1'b0;
         done0_q       <= 1'b0;
         done1_q       <= 1'b0;
         mem_addr_en_q <= 1'b0;
         mem_in_en_q   <= 1'b0;
         mem_out_en_q  <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         rdata_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_vld) begin
                  port_q        <= pick_port;
                  we_q          <= (pick_port == PORT_DMA) ? we1 : we0;
                  mem_addr_q    <= (pick_port == PORT_DMA) ? addr1 : addr0;
                  mem_wdata_q   <= (pick_port == PORT_DMA) ? wdata1 : wdata0;
                  gnt0_q        <= (pick_port == PORT_CPU);
                  gnt1_q        <= (pick_port == PORT_DMA);
                  mem_addr_en_q <= 1'b1;
                  state_q       <= ADDR;
               end
            end
            ADDR: begin
               mem_addr_en_q <= 1'b0;
               mem_in_en_q   <= we_q;
               mem_out_en_q  <= ~we_q;
               state_q       <= XFER;
            end
            XFER: begin
               if (!we_q) begin
                  rdata_q <= mem_rdata;
               end
               mem_in_en_q  <= 1'b0;
               mem_out_en_q <= 1'b0;
               done0_q      <= (port_q == PORT_CPU);
               done1_q      <= (port_q == PORT_DMA);
               state_q      <= RESP;
            end
            RESP: begin
               gnt0_q  <= 1'b0;
               gnt1_q  <= 1'b0;
               done0_q <= 1'b0;
               done1_q <= 1'b0;
               last_q  <= port_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt0        = gnt0_q;
   assign gnt1        = gnt1_q;
   assign done0       = done0_q;
   assign done1       = done1_q;
   assign rdata       = rdata_q;
   assign mem_addr_en = mem_addr_en_q;
   assign mem_addr    = mem_addr_q;
   assign mem_in_en   = mem_in_en_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_out_en  = mem_out_en_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-ported memory model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, we0, req1, we1;
   logic [15:0] addr0, wdata0, addr1, wdata1;
   logic        gnt0, done0, gnt1, done1;
   logic [15:0] rdata;
   logic        mem_addr_en, mem_in_en, mem_out_en;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .req0        (req0),
      .we0         (we0),
      .addr0       (addr0),
      .wdata0      (wdata0),
      .gnt0        (gnt0),
      .done0       (done0),
      .req1        (req1),
      .we1         (we1),
      .addr1       (addr1),
      .wdata1      (wdata1),
      .gnt1        (gnt1),
      .done1       (done1),
      .rdata       (rdata),
      .mem_addr_en (mem_addr_en),
      .mem_addr    (mem_addr),
      .mem_in_en   (mem_in_en),
      .mem_wdata   (mem_wdata),
      .mem_out_en  (mem_out_en),
      .mem_rdata   (mem_rdata)
   );

   // Memory model: MAR latched on posedge, access on negedge.
   logic [15:0] mem_arr [0:65535];
   logic [15:0] mar = 16'h0;
   initial mem_rdata = 16'h0;
   always @(posedge clk) if (mem_addr_en) mar <= mem_addr;
   always @(negedge clk) begin
      if (mem_in_en)  mem_arr[mar] = mem_wdata;
      if (mem_out_en) mem_rdata = mem_arr[mar];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
      tick(); tick();
      rst = 1'b0;
      n_checks++;
      if ({gnt0, gnt1, done0, done1, mem_addr_en, mem_in_en, mem_out_en} !== 7'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 0000000",
            {gnt0, gnt1, done0, done1, mem_addr_en, mem_in_en, mem_out_en});
      end
      n_checks++;
      if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
         n_fail++; $display("FAIL reset_mem_bus: addr=%h wdata=%h want 0", mem_addr, mem_wdata);
      end
      n_checks++;
      if (rdata !== 16'h0) begin
         n_fail++; $display("FAIL reset_rdata: got %h want 0000", rdata);
      end
   endtask

   task automatic test_single_read();
      req0 = 1; we0 = 0; addr0 = 16'h0010;
      tick();
      n_checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_addr_en !== 1'b1 || mem_addr !== 16'h0010) begin
         n_fail++; $display("FAIL read_grant: gnt0=%b gnt1=%b aen=%b addr=%h want 1 0 1 0010",
            gnt0, gnt1, mem_addr_en, mem_addr);
      end
      tick();
      n_checks++;
      if (mem_addr_en !== 1'b0 || mem_out_en !== 1'b1 || mem_in_en !== 1'b0) begin
         n_fail++; $display("FAIL read_xfer: aen=%b oen=%b ien=%b want 0 1 0",
            mem_addr_en, mem_out_en, mem_in_en);
      end
      tick();
      n_checks++;
      if (done0 !== 1'b1 || done1 !== 1'b0 || rdata !== 16'hBEEF || mem_out_en !== 1'b0) begin
         n_fail++; $display("FAIL read_done: done0=%b done1=%b rdata=%h oen=%b want 1 0 beef 0",
            done0, done1, rdata, mem_out_en);
      end
      req0 = 0;
      tick();
      n_checks++;
      if (gnt0 !== 1'b0 || done0 !== 1'b0 || rdata !== 16'hBEEF) begin
         n_fail++; $display("FAIL read_release: gnt0=%b done0=%b rdata=%h want 0 0 beef",
            gnt0, done0, rdata);
      end
   endtask

   task automatic test_write_read();
      int in_cnt;
      in_cnt = 0;
      req1 = 1; we1 = 1; addr1 = 16'h00FF; wdata1 = 16'h1234;
      tick();
      n_checks++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_wdata !== 16'h1234 || mem_addr !== 16'h00FF) begin
         n_fail++; $display("FAIL write_grant: gnt1=%b gnt0=%b wdata=%h addr=%h want 1 0 1234 00ff",
            gnt1, gnt0, mem_wdata, mem_addr);
      end
      for (int i = 0; i < 3; i++) begin
         if (mem_in_en === 1'b1) in_cnt++;
         if (i == 2) begin
            n_checks++;
            if (done1 !== 1'b1 || rdata !== 16'hBEEF || mem_out_en !== 1'b0) begin
               n_fail++; $display("FAIL write_done: done1=%b rdata=%h oen=%b want 1 beef 0",
                  done1, rdata, mem_out_en);
            end
            req1 = 0;
         end
         tick();
      end
      n_checks++;
      if (in_cnt != 1) begin
         n_fail++; $display("FAIL write_in_en_len: got %0d cycles want 1", in_cnt);
      end
      req1 = 1; we1 = 0; wdata1 = 16'h0;
      tick(); tick(); tick();
      n_checks++;
      if (done1 !== 1'b1 || rdata !== 16'h1234) begin
         n_fail++; $display("FAIL write_readback: done1=%b rdata=%h want 1 1234", done1, rdata);
      end
      req1 = 0;
      tick();
   endtask

   task automatic test_contention();
      logic exp_port [4];
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_port = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      rst = 1;
      tick();
      rst = 0;
      req0 = 1; we0 = 0; addr0 = 16'h0010;
      req1 = 1; we1 = 0; addr1 = 16'h00FF;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (gnt0 !== ~exp_port[i] || gnt1 !== exp_port[i]) begin
            n_fail++; $display("FAIL contend_grant[%0d]: gnt0=%b gnt1=%b want port %0d",
               i, gnt0, gnt1, exp_port[i]);
         end
         tick(); tick();
         n_checks++;
         if (done0 !== ~exp_port[i] || done1 !== exp_port[i] ||
             rdata !== (exp_port[i] ? 16'h1234 : 16'hBEEF)) begin
            n_fail++; $display("FAIL contend_done[%0d]: done0=%b done1=%b rdata=%h want port %0d",
               i, done0, done1, rdata, exp_port[i]);
         end
         tick();
         n_checks++;
         if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            n_fail++; $display("FAIL contend_idle[%0d]: gnt0=%b gnt1=%b want 0 0", i, gnt0, gnt1);
         end
      end
      req0 = 0; req1 = 0;
      tick();
   endtask

   task automatic test_cmd_latch();
      mem_arr[16'h0020] = 16'hAAAA;
      mem_arr[16'h0030] = 16'h5555;
      req0 = 1; we0 = 0; addr0 = 16'h0020;
      tick();
      addr0 = 16'h0030;
      tick();
      req0 = 0;
      n_checks++;
      if (mem_addr !== 16'h0020 || mar !== 16'h0020) begin
         n_fail++; $display("FAIL latch_addr: mem_addr=%h mar=%h want 0020", mem_addr, mar);
      end
      tick();
      n_checks++;
      if (done0 !== 1'b1 || rdata !== 16'hAAAA) begin
         n_fail++; $display("FAIL latch_done: done0=%b rdata=%h want 1 aaaa", done0, rdata);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      req1 = 1; we1 = 1; addr1 = 16'h0040; wdata1 = 16'h7777;
      tick(); tick();
      n_checks++;
      if (mem_in_en !== 1'b1 || gnt1 !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_xfer: ien=%b gnt1=%b want 1 1", mem_in_en, gnt1);
      end
      rst = 1; req1 = 0;
      tick();
      rst = 0;
      n_checks++;
      if ({gnt0, gnt1, done0, done1, mem_addr_en, mem_in_en, mem_out_en} !== 7'b0 ||
          mem_addr !== 16'h0 || mem_wdata !== 16'h0 || rdata !== 16'h0) begin
         n_fail++; $display("FAIL rstmid_clear: ctrl=%b addr=%h wdata=%h rdata=%h want all 0",
            {gnt0, gnt1, done0, done1, mem_addr_en, mem_in_en, mem_out_en},
            mem_addr, mem_wdata, rdata);
      end
      req0 = 1; we0 = 0; addr0 = 16'h0010;
      req1 = 1; we1 = 0; addr1 = 16'h00FF;
      tick();
      n_checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_first: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
      end
      req1 = 0;
      tick(); tick();
      n_checks++;
      if (done0 !== 1'b1 || done1 !== 1'b0 || rdata !== 16'hBEEF) begin
         n_fail++; $display("FAIL rstmid_done: done0=%b done1=%b rdata=%h want 1 0 beef",
            done0, done1, rdata);
      end
      req0 = 0;
      tick();
   endtask

   task automatic test_idle();
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if ({gnt0, gnt1, done0, done1, mem_addr_en, mem_in_en, mem_out_en} !== 7'b0 ||
             rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL idle[%0d]: ctrl=%b rdata=%h want 0000000 beef", i,
               {gnt0, gnt1, done0, done1, mem_addr_en, mem_in_en, mem_out_en}, rdata);
         end
      end
   endtask

   initial begin
      mem_arr[16'h0010] = 16'hBEEF;
      test_reset();
      test_single_read();
      test_write_read();
      test_contention();
      test_cmd_latch();
      test_reset_mid();
      test_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer for the single-ported 16-bit main memory.
- Port 0 is the CPU. Port 1 is the DMA/IO requester.
- Grants one requester at a time and runs the memory's three-step protocol:
  - latch MAR (addr_en);
  - negedge read or write (out_en / in_en);
  - capture the read data.
- Returns a done pulse to the granted requester. Sits between the requesters and memory; memory is driven only by this block.

Parameters:
- ADDR_W, 16, address width, matching the memory MAR width.
- DATA_W, 16, data word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req0  in  1  port 0 (CPU) request; held until done0.
- we0  in  1  port 0 write (1) or read (0).
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 transaction in progress.
- done0  out  1  one-cycle completion pulse for port 0.
- req1, we1, addr1, wdata1, gnt1, done1: same as port 0, for port 1.
- rdata  out  DATA_W  read data; valid in the done cycle and held until the next read completes.
- mem_addr_en  out  1  to memory addr_en.
- mem_addr  out  ADDR_W  to memory addr.
- mem_in_en  out  1  to memory in_en (write).
- mem_wdata  out  DATA_W  to memory in.
- mem_out_en  out  1  to memory out_en (read).
- mem_rdata  in  DATA_W  from memory out.

Behaviour:
- Reset (rst=1 at a posedge) takes effect on every register:
  - state=IDLE, last=1 (so port 0 wins first);
  - all gnt, done and mem_*_en = 0;
  - mem_addr, mem_wdata and rdata = 0.
- Reset mid-transaction aborts it. No done is issued, and the requester must re-request.
- All outputs are registered and change on posedge clk only.
- FSM has four states: IDLE, ADDR, XFER, RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise select a winner (see arbitration).
  - Latch the winner's we, addr and wdata into the command register.
  - Set gnt for the winner, set mem_addr_en=1 and mem_addr=addr, go to ADDR.
- ADDR:
  - Memory latches MAR on this cycle's closing posedge.
  - Drop mem_addr_en.
  - Set mem_in_en (if we) or mem_out_en (if read), go to XFER.
- XFER:
  - Memory performs the access at the mid-cycle negedge.
  - At the closing posedge: if read, rdata <= mem_rdata.
  - Clear the enables, pulse done for the granted port, go to RESP.
- RESP:
  - done is high for exactly this cycle; gnt is still high.
  - At the closing posedge: gnt cleared, done cleared, last <= granted port, go to IDLE.
- Latency and throughput:
  - Request sampled in IDLE to done high = 3 cycles.
  - One access per 4 cycles, including the return to IDLE.
  - No back-to-back grant skips IDLE.
- Arbitration (default, round-robin):
  - If only one req is high, that port wins.
  - If both are high, the port not equal to last wins.
- Command latching: addr, we and wdata are captured at grant. Requester changes after grant have no effect on the transaction in flight.
- req handling:
  - Dropping req before grant withdraws the request.
  - Dropping req after grant is ignored; the transaction completes and done still pulses.
- A requester holding req through done is re-arbitrated in the next IDLE. Under round-robin it loses to a waiting other port.
- Only one of mem_addr_en, mem_in_en, mem_out_en is high in any cycle.
- mem_in_en and mem_out_en are never high together.
- mem_addr and mem_wdata hold their values until the next grant.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. When both requests are high, port 0 always wins and last is ignored. Port 1 can starve.
- Undefined: round-robin as above.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, ADDR, XFER, RESP);
  - ADDR_W and DATA_W defaults;
  - port index constants PORT_CPU=0 and PORT_DMA=1.
- One sub-module, mem_arb_pick: a combinational 2-way round-robin/priority picker. Inputs: req0, req1, last. Output: winner index and valid.
- The FSM and datapath stay in mem_arbiter.

Test Plan:
- Single read: preload mem[0x0010]=0xBEEF, pulse req0 with we0=0 and addr0=0x0010.
  - Expect gnt0 next cycle.
  - Expect mem_addr_en for 1 cycle, then mem_out_en for 1 cycle.
  - Expect done0 3 cycles after req and rdata=0xBEEF.
- Single write then read: port 1 writes 0x1234 to 0x00FF, then port 1 reads 0x00FF.
  - Expect mem_in_en for exactly 1 cycle.
  - Expect rdata=0x1234 on the second done1.
- Contention: req0 and req1 both high from reset, both held, 4 transactions.
  - Round-robin: grants go 0,1,0,1 with no gaps beyond IDLE.
  - With MEM_ARB_FIXED_PRIO_EN: grants go 0,0,0,0.
- Command latching: change addr0 from 0x0020 to 0x0030 in the ADDR cycle.
  - Expect memory accessed at 0x0020.
  - Expect done0 still issued after req0 drops in XFER.
- Reset mid-op: assert rst during XFER of a port 1 write.
  - Expect all outputs 0 next cycle, no done1, state IDLE.
  - A fresh req0 is granted first.
- Idle: no requests for 10 cycles.
  - Expect all mem_*_en, gnt and done held at 0.
  - Expect rdata unchanged.
